// File: rtl/switch_pkg.sv
// Shared types for the switch datapath: default packet field widths, packet
// record and arbiter grant encoding.
package switch_pkg;

   localparam int ADDR_WIDTH = 8;
   localparam int DATA_WIDTH = 16;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } pkt_t;

   typedef enum logic {G0, G1} grant_t;

endpackage

// File: rtl/sw_fifo.sv
// Small synchronous FIFO of packets. Full/empty come straight from the
// registered occupancy count, so they carry no path from push/pop.
module sw_fifo
   import switch_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = pkt_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  T     din,
   output T     dout,
   output logic full,
   output logic empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign dout  = mem_q[rd_ptr_q];

   // A full FIFO refuses the push even when a pop frees a slot this cycle.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/switch_ingress_arb.sv
// Two-source ingress buffer with round-robin merge into the single
// addr/data/vld stream feeding switch; also counts packets per source.
module switch_ingress_arb #(
   parameter int ADDR_WIDTH = switch_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = switch_pkg::DATA_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s0_vld,
   output logic                  s0_rdy,
   input  logic [ADDR_WIDTH-1:0] s0_addr,
   input  logic [DATA_WIDTH-1:0] s0_data,
   input  logic                  s1_vld,
   output logic                  s1_rdy,
   input  logic [ADDR_WIDTH-1:0] s1_addr,
   input  logic [DATA_WIDTH-1:0] s1_data,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  vld,
   output logic [15:0]           cnt0,
   output logic [15:0]           cnt1
);
   import switch_pkg::*;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } port_pkt_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   port_pkt_t din0, din1, dout0, dout1;
   logic      full0, full1, empty0, empty1;
   logic      pop0, pop1;

   grant_t                last_grant_q, last_grant_d;
   logic                  vld_q, vld_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [15:0]           cnt0_q, cnt0_d;
   logic [15:0]           cnt1_q, cnt1_d;

   assign din0   = '{addr: s0_addr, data: s0_data};
   assign din1   = '{addr: s1_addr, data: s1_data};
   assign s0_rdy = !full0;
   assign s1_rdy = !full1;

   sw_fifo #(.DEPTH(DEPTH), .T(port_pkt_t)) u_fifo0 (
      .clk(clk), .rst(rst), .push(s0_vld), .pop(pop0),
      .din(din0), .dout(dout0), .full(full0), .empty(empty0)
   );

   sw_fifo #(.DEPTH(DEPTH), .T(port_pkt_t)) u_fifo1 (
      .clk(clk), .rst(rst), .push(s1_vld), .pop(pop1),
      .din(din1), .dout(dout1), .full(full1), .empty(empty1)
   );

   // On a tie the source that was not served last wins.
   always_comb begin
      pop0         = 1'b0;
      pop1         = 1'b0;
      last_grant_d = last_grant_q;
      vld_d        = 1'b0;
      addr_d       = addr_q;
      data_d       = data_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;
      if (!empty0 && !empty1) begin
         if (last_grant_q == G1) pop0 = 1'b1;
         else                    pop1 = 1'b1;
      end else if (!empty0) begin
         pop0 = 1'b1;
      end else if (!empty1) begin
         pop1 = 1'b1;
      end
      if (pop0) begin
         last_grant_d = G0;
         vld_d        = 1'b1;
         addr_d       = dout0.addr;
         data_d       = dout0.data;
         cnt0_d       = sat_inc(cnt0_q);
      end
      if (pop1) begin
         last_grant_d = G1;
         vld_d        = 1'b1;
         addr_d       = dout1.addr;
         data_d       = dout1.data;
         cnt1_d       = sat_inc(cnt1_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= G1;
         vld_q        <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         vld_q        <= vld_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end

   assign vld  = vld_q;
   assign addr = addr_q;
   assign data = data_q;
   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;

endmodule

// File: tb/tb_switch_ingress_arb.sv
// Bench for switch_ingress_arb: directed scenarios plus random traffic,
// checked against a queue-based model of the two sources and the merge.
module tb_switch_ingress_arb;

   localparam int AW    = 8;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          s0_vld, s1_vld, s0_rdy, s1_rdy, vld;
   logic [AW-1:0] s0_addr, s1_addr, addr;
   logic [DW-1:0] s0_data, s1_data, data;
   logic [15:0]   cnt0, cnt1;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: queued packets per source, who was served last, expected outputs.
   logic [AW+DW-1:0] q0[$], q1[$];
   int               m_last;
   logic             exp_vld;
   logic [AW-1:0]    exp_addr;
   logic [DW-1:0]    exp_data;
   logic [15:0]      exp_cnt0, exp_cnt1;

   always #5 clk = ~clk;

   switch_ingress_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .s0_vld(s0_vld), .s0_rdy(s0_rdy), .s0_addr(s0_addr), .s0_data(s0_data),
      .s1_vld(s1_vld), .s1_rdy(s1_rdy), .s1_addr(s1_addr), .s1_data(s1_data),
      .addr(addr), .data(data), .vld(vld), .cnt0(cnt0), .cnt1(cnt1)
   );

   task automatic model_reset();
      q0.delete();
      q1.delete();
      m_last   = 1;
      exp_vld  = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      exp_cnt0 = '0;
      exp_cnt1 = '0;
   endtask

   task automatic apply_reset();
      s0_vld = 1'b0;
      s1_vld = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   // One clock: present inputs, advance the model, return at posedge+1.
   task automatic cycle(input bit v0, input logic [AW+DW-1:0] p0,
                        input bit v1, input logic [AW+DW-1:0] p1,
                        output bit acc0, output bit acc1);
      int src;
      s0_vld = v0; {s0_addr, s0_data} = p0;
      s1_vld = v1; {s1_addr, s1_data} = p1;
      acc0 = v0 && (q0.size() < DEPTH);
      acc1 = v1 && (q1.size() < DEPTH);
      src = -1;
      if (q0.size() != 0 && q1.size() != 0) src = (m_last == 0) ? 1 : 0;
      else if (q0.size() != 0)              src = 0;
      else if (q1.size() != 0)              src = 1;
      exp_vld = (src >= 0);
      if (src == 0) begin
         {exp_addr, exp_data} = q0.pop_front();
         if (exp_cnt0 != 16'hFFFF) exp_cnt0 = exp_cnt0 + 16'd1;
         m_last = 0;
      end else if (src == 1) begin
         {exp_addr, exp_data} = q1.pop_front();
         if (exp_cnt1 != 16'hFFFF) exp_cnt1 = exp_cnt1 + 16'd1;
         m_last = 1;
      end
      if (acc0) q0.push_back(p0);
      if (acc1) q1.push_back(p1);
      @(posedge clk);
      #1;
      s0_vld = 1'b0;
      s1_vld = 1'b0;
   endtask

   task automatic test_reset();
      n_checks += 7;
      if (vld !== 1'b0)      begin n_fail++; $display("FAIL reset_vld got=%b want=0", vld); end
      if (addr !== 8'h00)    begin n_fail++; $display("FAIL reset_addr got=%h want=00", addr); end
      if (data !== 16'h0)    begin n_fail++; $display("FAIL reset_data got=%h want=0000", data); end
      if (cnt0 !== 16'h0)    begin n_fail++; $display("FAIL reset_cnt0 got=%h want=0000", cnt0); end
      if (cnt1 !== 16'h0)    begin n_fail++; $display("FAIL reset_cnt1 got=%h want=0000", cnt1); end
      if (s0_rdy !== 1'b1)   begin n_fail++; $display("FAIL reset_s0_rdy got=%b want=1", s0_rdy); end
      if (s1_rdy !== 1'b1)   begin n_fail++; $display("FAIL reset_s1_rdy got=%b want=1", s1_rdy); end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_latency();
      bit a0, a1;
      apply_reset();
      cycle(1'b1, {8'h10, 16'hA5A5}, 1'b0, '0, a0, a1);
      n_checks++;
      if (vld !== 1'b0) begin n_fail++; $display("FAIL lat_n1_vld got=%b want=0", vld); end
      cycle(1'b0, '0, 1'b0, '0, a0, a1);
      n_checks += 4;
      if (vld !== 1'b1)      begin n_fail++; $display("FAIL lat_n2_vld got=%b want=1", vld); end
      if (addr !== 8'h10)    begin n_fail++; $display("FAIL lat_addr got=%h want=10", addr); end
      if (data !== 16'hA5A5) begin n_fail++; $display("FAIL lat_data got=%h want=a5a5", data); end
      if (cnt0 !== 16'd1)    begin n_fail++; $display("FAIL lat_cnt0 got=%0d want=1", cnt0); end
      cycle(1'b0, '0, 1'b0, '0, a0, a1);
      n_checks += 2;
      if (vld !== 1'b0)   begin n_fail++; $display("FAIL lat_n3_vld got=%b want=0", vld); end
      if (addr !== 8'h10) begin n_fail++; $display("FAIL lat_hold_addr got=%h want=10", addr); end
   endtask

   task automatic test_contention();
      bit a0, a1;
      apply_reset();
      cycle(1'b1, {8'h01, 16'h1111}, 1'b1, {8'h81, 16'h2222}, a0, a1);
      cycle(1'b0, '0, 1'b0, '0, a0, a1);
      n_checks += 2;
      if (vld !== 1'b1)   begin n_fail++; $display("FAIL cont_first_vld got=%b want=1", vld); end
      if (addr !== 8'h01) begin n_fail++; $display("FAIL cont_first_addr got=%h want=01", addr); end
      cycle(1'b0, '0, 1'b0, '0, a0, a1);
      n_checks += 3;
      if (vld !== 1'b1)      begin n_fail++; $display("FAIL cont_second_vld got=%b want=1", vld); end
      if (addr !== 8'h81)    begin n_fail++; $display("FAIL cont_second_addr got=%h want=81", addr); end
      if (data !== 16'h2222) begin n_fail++; $display("FAIL cont_second_data got=%h want=2222", data); end
      cycle(1'b0, '0, 1'b0, '0, a0, a1);
      n_checks += 3;
      if (vld !== 1'b0)  begin n_fail++; $display("FAIL cont_end_vld got=%b want=0", vld); end
      if (cnt0 !== 16'd1) begin n_fail++; $display("FAIL cont_cnt0 got=%0d want=1", cnt0); end
      if (cnt1 !== 16'd1) begin n_fail++; $display("FAIL cont_cnt1 got=%0d want=1", cnt1); end
   endtask

   task automatic test_back_to_back();
      bit a0, a1;
      int i0, i1;
      logic [AW+DW-1:0] outq[$];
      logic [AW+DW-1:0] want;
      apply_reset();
      i0 = 0; i1 = 0;
      for (int c = 0; c < 40; c++) begin
         cycle(i0 < 8, {8'(i0), 16'h0A00 + 16'(i0)}, i1 < 8, {8'h80 + 8'(i1), 16'h0B00 + 16'(i1)}, a0, a1);
         if (a0) i0++;
         if (a1) i1++;
         if (vld) outq.push_back({addr, data});
         n_checks++;
         if (vld !== exp_vld || (exp_vld && {addr, data} !== {exp_addr, exp_data})) begin
            n_fail++;
            $display("FAIL b2b_cycle%0d got=%b/%h/%h want=%b/%h/%h", c, vld, addr, data, exp_vld, exp_addr, exp_data);
         end
      end
      n_checks += 3;
      if (outq.size() != 16) begin n_fail++; $display("FAIL b2b_pulses got=%0d want=16", outq.size()); end
      if (cnt0 !== 16'd8) begin n_fail++; $display("FAIL b2b_cnt0 got=%0d want=8", cnt0); end
      if (cnt1 !== 16'd8) begin n_fail++; $display("FAIL b2b_cnt1 got=%0d want=8", cnt1); end
      for (int k = 0; k < outq.size() && k < 16; k++) begin
         want = (k % 2 == 0) ? {8'(k / 2), 16'h0A00 + 16'(k / 2)}
                             : {8'h80 + 8'(k / 2), 16'h0B00 + 16'(k / 2)};
         n_checks++;
         if (outq[k] !== want) begin n_fail++; $display("FAIL b2b_order%0d got=%h want=%h", k, outq[k], want); end
      end
   endtask

   task automatic test_s1_stream();
      bit a0, a1;
      int i1;
      logic [AW+DW-1:0] sent[$], outq[$];
      logic [AW+DW-1:0] p;
      apply_reset();
      i1 = 0;
      for (int c = 0; c < 10; c++) begin
         p = {8'h40 + 8'(i1), 16'($urandom)};
         cycle(1'b0, '0, i1 < 6, p, a0, a1);
         if (a1) begin sent.push_back(p); i1++; end
         if (vld) outq.push_back({addr, data});
         n_checks++;
         if (s1_rdy !== 1'b1) begin n_fail++; $display("FAIL s1_rdy_cycle%0d got=%b want=1", c, s1_rdy); end
      end
      n_checks++;
      if (outq.size() != 6) begin n_fail++; $display("FAIL s1_count got=%0d want=6", outq.size()); end
      for (int k = 0; k < outq.size() && k < sent.size(); k++) begin
         n_checks++;
         if (outq[k] !== sent[k]) begin n_fail++; $display("FAIL s1_order%0d got=%h want=%h", k, outq[k], sent[k]); end
      end
   endtask

   task automatic test_reset_midop();
      bit a0, a1;
      bit seen;
      apply_reset();
      for (int i = 0; i < 6; i++)
         cycle(1'b1, {8'h20 + 8'(i), 16'h5000 + 16'(i)}, 1'b1, {8'hA0 + 8'(i), 16'h6000 + 16'(i)}, a0, a1);
      n_checks += 2;
      if (vld !== exp_vld) begin n_fail++; $display("FAIL mid_pre_vld got=%b want=%b", vld, exp_vld); end
      if (s0_rdy !== (q0.size() < DEPTH)) begin n_fail++; $display("FAIL mid_pre_rdy got=%b want=%b", s0_rdy, q0.size() < DEPTH); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (vld !== 1'b0) begin n_fail++; $display("FAIL mid_async_vld got=%b want=0", vld); end
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      n_checks += 2;
      if (cnt0 !== 16'd0)  begin n_fail++; $display("FAIL mid_cnt0 got=%0d want=0", cnt0); end
      if (s0_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_s0_rdy got=%b want=1", s0_rdy); end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, '0, 1'b0, '0, a0, a1);
         if (vld !== 1'b0) seen = 1'b1;
      end
      n_checks += 2;
      if (seen !== 1'b0)  begin n_fail++; $display("FAIL mid_discard got=%b want=0", seen); end
      if (cnt0 !== 16'd0) begin n_fail++; $display("FAIL mid_cnt0_after got=%0d want=0", cnt0); end
   endtask

   task automatic test_saturation();
      bit a0, a1;
      apply_reset();
      force dut.cnt0_q = 16'hFFFE;
      #1 release dut.cnt0_q;
      exp_cnt0 = 16'hFFFE;
      n_checks++;
      if (cnt0 !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload got=%h want=fffe", cnt0); end
      for (int i = 0; i < 6; i++) begin
         cycle(i < 3, {8'h30 + 8'(i), 16'hC000 + 16'(i)}, 1'b0, '0, a0, a1);
         n_checks++;
         if (cnt0 !== exp_cnt0) begin n_fail++; $display("FAIL sat_cycle%0d got=%h want=%h", i, cnt0, exp_cnt0); end
      end
      n_checks++;
      if (cnt0 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_final got=%h want=ffff", cnt0); end
   endtask

   task automatic test_random();
      bit a0, a1;
      bit v0, v1;
      logic r0, r1;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         v0 = (c < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         v1 = (c < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
         cycle(v0, 24'($urandom), v1, 24'($urandom), a0, a1);
         r0 = (q0.size() < DEPTH);
         r1 = (q1.size() < DEPTH);
         n_checks++;
         if ({vld, addr, data, cnt0, cnt1, s0_rdy, s1_rdy} !==
             {exp_vld, exp_addr, exp_data, exp_cnt0, exp_cnt1, r0, r1}) begin
            n_fail++;
            $display("FAIL rand_cycle%0d got=%b %h %h %0d %0d %b%b want=%b %h %h %0d %0d %b%b", c,
                     vld, addr, data, cnt0, cnt1, s0_rdy, s1_rdy,
                     exp_vld, exp_addr, exp_data, exp_cnt0, exp_cnt1, r0, r1);
         end
      end
   endtask

   initial begin
      rst     = 1'b1;
      s0_vld  = 1'b0;
      s1_vld  = 1'b0;
      s0_addr = '0;
      s0_data = '0;
      s1_addr = '0;
      s1_data = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_latency();
      test_contention();
      test_back_to_back();
      test_s1_stream();
      test_reset_midop();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/switch_ingress_arb.md
# switch_ingress_arb

Ingress stage directly upstream of the address-routing `switch`. It accepts packets from two independent sources over valid/ready handshakes and buffers each source in its own small FIFO. A round-robin arbiter merges them into the single `addr`/`data`/`vld` stream that drives `switch`, at most one packet per cycle. `switch` has no backpressure, so this block owns all flow control toward the sources.

## Interface
- `ADDR_WIDTH`, default 8: packet address width; matches `switch` `addr`.
- `DATA_WIDTH`, default 16: packet payload width; matches `switch` `data`.
- `DEPTH`, default 4: entries per ingress FIFO; must be a power of two, ≥2.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `s0_vld`  in  1  source 0 presents a packet.
- `s0_rdy`  out  1  source 0 may transfer; transfer = `s0_vld && s0_rdy`.
- `s0_addr`  in  ADDR_WIDTH  source 0 packet address.
- `s0_data`  in  DATA_WIDTH  source 0 packet payload.
- `s1_vld`, `s1_rdy`, `s1_addr`, `s1_data`: same as source 0, for source 1.
- `addr`  out  ADDR_WIDTH  packet address to `switch`.
- `data`  out  DATA_WIDTH  packet payload to `switch`.
- `vld`  out  1  `addr`/`data` valid this cycle; single-cycle pulse per packet.
- `cnt0`, `cnt1`  out  16 each  packets forwarded from source 0/1; saturate at 16'hFFFF.

## Operation
- Each source writes its own FIFO of `{addr, data}`.
- `sN_rdy = !fullN`, driven from the registered occupancy count only, with no combinational path from `vld` or the pop. When a FIFO is full, no push occurs even if a pop happens in the same cycle.
- When a FIFO is not full, a push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Pointers wrap modulo `DEPTH`. Occupancy is kept as a `$clog2(DEPTH)+1`-bit count.
- Arbiter state is `last_grant` ∈ {G0, G1}; reset value is G1, so source 0 wins the first tie.
  - Only FIFO N non-empty: pop N, set `last_grant`=GN.
  - Both non-empty: pop the source that is not `last_grant`, then update `last_grant`.
  - Both empty: no pop; `last_grant` holds.
- The popped entry is loaded into the output registers (`addr`, `data`) with `vld`=1 next cycle. With no pop, `vld`=0 and `addr`/`data` hold their last values.
- `cntN` increments on each pop from FIFO N and stops at 16'hFFFF.
- Reset values: `vld`=0, `addr`=0, `data`=0, `cnt0`=`cnt1`=0, both FIFOs empty, `s0_rdy`=`s1_rdy`=1 (ready asserted during reset).
- Reset mid-operation: all buffered packets are discarded without being forwarded. `vld` falls asynchronously with `rst`.

## Timing
- Latency: a push accepted in cycle N to an empty FIFO with no contention gives `vld`=1 in cycle N+2.
- Throughput: one packet per cycle total. Under continuous contention each source gets exactly every other slot.
- `sN_rdy` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop from a full FIFO.
- Inputs `sN_addr`/`sN_data` are sampled only on a transfer cycle. They may change freely otherwise.
- There is no combinational path from any input to any output.

## Structure
- Package `switch_pkg` holds:
  - `ADDR_WIDTH`/`DATA_WIDTH` defaults, shared with `switch`;
  - `typedef struct packed { logic [ADDR_WIDTH-1:0] addr; logic [DATA_WIDTH-1:0] data; } pkt_t`;
  - `typedef enum logic {G0, G1} grant_t`.
- Sub-module `sw_fifo`: synchronous FIFO parameterised by `DEPTH` and `pkt_t`, with ports `push`/`pop`/`din`/`dout`/`full`/`empty`. It is instantiated twice.
- Top level: arbiter, output registers, counters.

## Test plan
- Reset release, single push on s0 (`addr`=8'h10, `data`=16'hA5A5) in cycle 3 -> `vld`=1 with `addr`=8'h10, `data`=16'hA5A5 in cycle 5 only; `cnt0`=1.
- Simultaneous single pushes on s0 (`addr`=8'h01) and s1 (`addr`=8'h81) in the same cycle, with `last_grant`=G1 -> s0 packet out first, s1 packet next cycle, `vld` high for 2 consecutive cycles.
- Both sources push 8 packets back-to-back -> output strictly alternates s0,s1,...; 16 `vld` pulses; `cnt0`=`cnt1`=8; order within each source preserved.
- Only s1 streams 6 packets, DEPTH=4 -> `s1_rdy` never drops (drained at 1/cycle); output order equals input order.
- Assert `rst` with 3 packets buffered in FIFO0 -> `vld` falls immediately, none of the 3 ever appear, `cnt0`=0, `s0_rdy`=1 after release.
- Force `cnt0` to 16'hFFFE, forward 3 s0 packets -> `cnt0` reads 16'hFFFF and holds.
